// File: rtl/uart_cmd_assembler_if.sv
// Purpose: groups the uart byte/ack signals and the SD command frame handshake of uart_cmd_assembler.
// Latency: n/a (signal bundle only).
// Backpressure: cmd_valid/cmd_ready on the frame; tx_en/tx_sending level handshake on the ack byte.
//
// Signals:
//   rx_data, rx_contains_data  uart receiver byte and "byte present" level
//   tx_sending                 uart transmitter busy level
//   tx_data, tx_en             ack byte and transmit request level
//   cmd_frame, cmd_valid       48-bit SD command frame offered downstream
//   cmd_ready                  SD command engine accepts frame
// Modports: master = assembler side, slave = uart/command-engine side.
interface uart_cmd_assembler_if;
  logic [7:0]  rx_data;
  logic        rx_contains_data;
  logic        tx_sending;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic [47:0] cmd_frame;
  logic        cmd_valid;
  logic        cmd_ready;

  modport master (
    input  rx_data, rx_contains_data, tx_sending, cmd_ready,
    output tx_data, tx_en, cmd_frame, cmd_valid
  );

  modport slave (
    output rx_data, rx_contains_data, tx_sending, cmd_ready,
    input  tx_data, tx_en, cmd_frame, cmd_valid
  );
endinterface

// File: rtl/uart_cmd_assembler.sv
// Purpose: assembles 5-byte host packets from the uart into a 48-bit SD command frame with CRC7, optional ack echo.
// Latency: last byte edge -> strobe (2 clk) -> 40 clk serial CRC -> cmd_valid; frame held until cmd_ready.
// Backpressure: frame holds under !cmd_ready; bytes arriving while not IDLE/COLLECT are dropped with err_overrun.
//
// Ports:
//   clk, reset     system clock, asynchronous active-low reset
//   bus (master)   rx_data/rx_contains_data/tx_sending in; tx_data/tx_en out; cmd_frame/cmd_valid out; cmd_ready in
//   busy           state != IDLE
//   err_start      1-cycle pulse: first byte prefix not 2'b01, byte dropped
//   err_timeout    1-cycle pulse: inter-byte timeout, partial packet discarded
//   err_overrun    1-cycle pulse: byte arrived during CRC/PRESENT/ACK, byte dropped
module uart_cmd_assembler #(
  parameter int TIMEOUT_CYCLES = 208320,
  parameter bit ACK_EN         = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_cmd_assembler_if.master  bus,
  output logic                  busy,
  output logic                  err_start,
  output logic                  err_timeout,
  output logic                  err_overrun
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    CRC      = 3'd2,
    PRESENT  = 3'd3,
    ACK_WAIT = 3'd4,
    ACK_REQ  = 3'd5
  } state_t;

  state_t        state;
  logic          rx_lvl_q;
  logic          strobe;
  logic [7:0]    byte_q;
  logic [2:0]    byte_cnt;
  logic [TW-1:0] timer;
  logic [39:0]   msg;
  logic [5:0]    bit_idx;
  logic [6:0]    crc;

  // Serial CRC7 (x^7 + x^3 + 1), message walked MSB first.
  logic [5:0] bit_pos;
  logic       msg_bit;
  logic       crc_fb;
  logic [6:0] crc_next;

  always_comb begin
    bit_pos  = 6'd39 - bit_idx;
    msg_bit  = msg[bit_pos];
    crc_fb   = msg_bit ^ crc[6];
    crc_next = {crc[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};
  end

  assign busy = (state != IDLE);

  // Byte strobe is registered together with the data so both stay aligned;
  // the uart holds rx_data steady while rx_contains_data is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_lvl_q <= 1'b0;
      strobe   <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      rx_lvl_q <= bus.rx_contains_data;
      strobe   <= bus.rx_contains_data & ~rx_lvl_q;
      byte_q   <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      byte_cnt      <= 3'd0;
      timer         <= '0;
      msg           <= 40'h0;
      bit_idx       <= 6'd0;
      crc           <= 7'h00;
      bus.tx_data   <= 8'h00;
      bus.tx_en     <= 1'b0;
      bus.cmd_frame <= 48'h0;
      bus.cmd_valid <= 1'b0;
      err_start     <= 1'b0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      err_start   <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (strobe) begin
            if (byte_q[7:6] == 2'b01) begin
              msg      <= {32'h0, byte_q};
              byte_cnt <= 3'd1;
              timer    <= '0;
              state    <= COLLECT;
            end else begin
              err_start <= 1'b1;
            end
          end
        end

        COLLECT: begin
          // A byte landing on the last timer cycle still counts.
          if (strobe) begin
            msg      <= {msg[31:0], byte_q};
            byte_cnt <= byte_cnt + 3'd1;
            timer    <= '0;
            if (byte_cnt == 3'd4) begin
              bit_idx <= 6'd0;
              crc     <= 7'h00;
              state   <= CRC;
            end
          end else if (timer == TIMER_LAST) begin
            err_timeout <= 1'b1;
            timer       <= '0;
            byte_cnt    <= 3'd0;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        CRC: begin
          if (strobe) err_overrun <= 1'b1;
          crc     <= crc_next;
          bit_idx <= bit_idx + 6'd1;
          if (bit_idx == 6'd39) begin
            bus.cmd_frame <= {msg, crc_next, 1'b1};
            bus.cmd_valid <= 1'b1;
            state         <= PRESENT;
          end
        end

        PRESENT: begin
          if (strobe) err_overrun <= 1'b1;
          if (bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            if (ACK_EN) begin
              bus.tx_data <= {2'b00, msg[37:32]};
              state       <= ACK_WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end

        ACK_WAIT: begin
          if (strobe) err_overrun <= 1'b1;
          if (!bus.tx_sending) begin
            bus.tx_en <= 1'b1;
            state     <= ACK_REQ;
          end
        end

        ACK_REQ: begin
          // Request stays up until the uart shows it started; it samples at baud rate.
          if (strobe) err_overrun <= 1'b1;
          if (bus.tx_sending) begin
            bus.tx_en <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
module tb_uart_cmd_assembler;
  localparam int TOUT = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, err_start, err_timeout, err_overrun;

  int errors = 0;
  int checks = 0;
  int n_start = 0;
  int n_timeout = 0;
  int n_overrun = 0;

  uart_cmd_assembler_if bus ();

  uart_cmd_assembler #(.TIMEOUT_CYCLES(TOUT), .ACK_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .busy        (busy),
    .err_start   (err_start),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_start)   n_start   <= n_start + 1;
    if (err_timeout) n_timeout <= n_timeout + 1;
    if (err_overrun) n_overrun <= n_overrun + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_contains_data = 1'b1;
    tick(3);
    bus.rx_contains_data = 1'b0;
    tick(2);
  endtask

  task automatic send_pkt(input logic [39:0] p);
    for (int i = 4; i >= 0; i--) send_byte(p[i*8 +: 8]);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    chk(tag, {63'b0, bus.cmd_valid}, 64'd1);
  endtask

  // Accept the presented frame and walk the ack handshake.
  task automatic accept_and_ack(input string tag, input logic [7:0] ack_byte);
    bus.tx_sending = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    chk({tag, "_valid_drop"}, {63'b0, bus.cmd_valid}, 64'd0);
    tick(3);
    chk({tag, "_ack_hold"}, {63'b0, bus.tx_en}, 64'd0);
    chk({tag, "_ack_busy"}, {63'b0, busy}, 64'd1);
    chk({tag, "_ack_byte"}, {56'b0, bus.tx_data}, {56'b0, ack_byte});
    bus.tx_sending = 1'b0;
    tick(2);
    chk({tag, "_tx_en_up"}, {63'b0, bus.tx_en}, 64'd1);
    tick(4);
    chk({tag, "_tx_en_held"}, {63'b0, bus.tx_en}, 64'd1);
    bus.tx_sending = 1'b1;
    tick(1);
    chk({tag, "_tx_en_down"}, {63'b0, bus.tx_en}, 64'd0);
    chk({tag, "_idle"}, {63'b0, busy}, 64'd0);
    bus.tx_sending = 1'b0;
    tick(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, {56'b0, bus.tx_data}, 64'd0);
    chk({tag, "_tx_en"}, {63'b0, bus.tx_en}, 64'd0);
    chk({tag, "_frame"}, {16'b0, bus.cmd_frame}, 64'd0);
    chk({tag, "_valid"}, {63'b0, bus.cmd_valid}, 64'd0);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_errs"}, {61'b0, err_start, err_timeout, err_overrun}, 64'd0);
  endtask

  initial begin
    int s0, t0, o0;
    bus.rx_data = 8'h00;
    bus.rx_contains_data = 1'b0;
    bus.tx_sending = 1'b0;
    bus.cmd_ready = 1'b0;

    // Reset state
    tick(3);
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    tick(2);

    // CMD0 frame, held under !cmd_ready, overrun byte ignored
    send_pkt(40'h40_00000000);
    wait_valid("cmd0_valid");
    chk("cmd0_frame", {16'b0, bus.cmd_frame}, 64'h0000_400000000095);
    tick(5);
    chk("cmd0_hold_valid", {63'b0, bus.cmd_valid}, 64'd1);
    o0 = n_overrun;
    send_byte(8'h55);
    tick(1);
    chk("overrun_pulse", 64'(n_overrun - o0), 64'd1);
    chk("overrun_frame", {16'b0, bus.cmd_frame}, 64'h0000_400000000095);
    chk("overrun_valid", {63'b0, bus.cmd_valid}, 64'd1);
    accept_and_ack("cmd0", 8'h00);

    // CMD8 and CMD17 frames
    send_pkt(40'h48_000001AA);
    wait_valid("cmd8_valid");
    chk("cmd8_frame", {16'b0, bus.cmd_frame}, 64'h0000_48000001AA87);
    accept_and_ack("cmd8", 8'h08);
    send_pkt(40'h51_00000000);
    wait_valid("cmd17_valid");
    chk("cmd17_frame", {16'b0, bus.cmd_frame}, 64'h0000_510000000055);
    accept_and_ack("cmd17", 8'h11);

    // Bad start byte dropped, then a normal packet
    s0 = n_start;
    send_byte(8'hC0);
    tick(1);
    chk("start_pulse", 64'(n_start - s0), 64'd1);
    chk("start_busy", {63'b0, busy}, 64'd0);
    send_pkt(40'h40_00000000);
    wait_valid("after_start_valid");
    chk("after_start_frame", {16'b0, bus.cmd_frame}, 64'h0000_400000000095);
    accept_and_ack("after_start", 8'h00);

    // Slow bytes just inside the timeout still assemble
    t0 = n_timeout;
    send_byte(8'h48);
    tick(TOUT - 10);
    send_byte(8'h00);
    tick(TOUT - 10);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    wait_valid("slow_valid");
    chk("slow_no_timeout", 64'(n_timeout - t0), 64'd0);
    chk("slow_frame", {16'b0, bus.cmd_frame}, 64'h0000_48000001AA87);
    accept_and_ack("slow", 8'h08);

    // Inter-byte timeout discards the partial packet
    t0 = n_timeout;
    send_byte(8'h40);
    send_byte(8'h00);
    chk("timeout_busy_before", {63'b0, busy}, 64'd1);
    tick(3 * TOUT);
    chk("timeout_pulse", 64'(n_timeout - t0), 64'd1);
    chk("timeout_idle", {63'b0, busy}, 64'd0);
    chk("timeout_no_valid", {63'b0, bus.cmd_valid}, 64'd0);

    // Reset mid-COLLECT
    send_byte(8'h40);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("midreset_busy_before", {63'b0, busy}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick(2);
    reset = 1'b1;
    tick(2);
    send_pkt(40'h48_000001AA);
    wait_valid("post_reset_valid");
    chk("post_reset_frame", {16'b0, bus.cmd_frame}, 64'h0000_48000001AA87);
    accept_and_ack("post_reset", 8'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
